// File: rtl/iob_bus_arb2.sv
// Two-master to one-slave bus arbiter for the IOb native interface.
// Round-robin or fixed-priority arbitration, one slave transaction outstanding.
module iob_bus_arb2 #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,

    input  logic                  m0_avalid_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic [DATA_W-1:0]     m0_wdata_i,
    input  logic [DATA_W/8-1:0]   m0_wstrb_i,
    output logic                  m0_ready_o,
    output logic [DATA_W-1:0]     m0_rdata_o,
    output logic                  m0_rvalid_o,

    input  logic                  m1_avalid_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    input  logic [DATA_W/8-1:0]   m1_wstrb_i,
    output logic                  m1_ready_o,
    output logic [DATA_W-1:0]     m1_rdata_o,
    output logic                  m1_rvalid_o,

    output logic                  s_avalid_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic [DATA_W/8-1:0]   s_wstrb_o,
    input  logic                  s_ready_i,
    input  logic [DATA_W-1:0]     s_rdata_i,
    input  logic                  s_rvalid_i,

    output logic                  grant_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   winner;
    logic   sel_avalid;
    logic   accept;
    logic   resp_hit;

    // Granted master's request is steered straight through to the slave
    assign sel_avalid = grant_q ? m1_avalid_i : m0_avalid_i;
    assign s_addr_o   = grant_q ? m1_addr_i   : m0_addr_i;
    assign s_wdata_o  = grant_q ? m1_wdata_i  : m0_wdata_i;
    assign s_wstrb_o  = grant_q ? m1_wstrb_i  : m0_wstrb_i;
    assign s_avalid_o = (state_q == REQ) && sel_avalid;
    assign accept     = s_avalid_o && s_ready_i;

    assign m0_ready_o = accept && !grant_q;
    assign m1_ready_o = accept && grant_q;

    assign resp_hit    = (state_q == RESP) && s_rvalid_i;
    assign m0_rvalid_o = resp_hit && !grant_q;
    assign m1_rvalid_o = resp_hit && grant_q;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    // Tie-break: fixed priority favours master 0, otherwise the one not served last
    always_comb begin
        winner = m1_avalid_i;
        if (m0_avalid_i && m1_avalid_i) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : !last_grant_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_avalid_i || m1_avalid_i) begin
                    grant_d = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!sel_avalid) begin
                    state_d = IDLE;
                end else if (s_ready_i) begin
                    last_grant_d = grant_q;
                    state_d      = (|s_wstrb_o) ? IDLE : RESP;
                end
            end
            RESP: begin
                if (s_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_iob_bus_arb2.sv
// Testbench for iob_bus_arb2: directed scenarios on round-robin and fixed-priority
// instances, plus randomized traffic checked against a transaction-level model.
module tb_iob_bus_arb2;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int          NTX = 24;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          m0_avalid, m1_avalid, s_ready, s_rvalid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_rdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;

    logic          m0_ready, m0_rvalid, m1_ready, m1_rvalid, s_avalid, grant, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_wstrb;

    logic          f_m0_ready, f_m0_rvalid, f_m1_ready, f_m1_rvalid, f_s_avalid, f_grant, f_busy;
    logic [DW-1:0] f_m0_rdata, f_m1_rdata, f_s_wdata;
    logic [AW-1:0] f_s_addr;
    logic [SW-1:0] f_s_wstrb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_bus_arb2 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .m0_avalid_i(m0_avalid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
        .m0_ready_o(m0_ready), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
        .m1_avalid_i(m1_avalid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
        .m1_ready_o(m1_ready), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
        .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
        .s_ready_i(s_ready), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid),
        .grant_o(grant), .busy_o(busy)
    );

    iob_bus_arb2 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .arst_n_i(arst_n),
        .m0_avalid_i(m0_avalid), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
        .m0_ready_o(f_m0_ready), .m0_rdata_o(f_m0_rdata), .m0_rvalid_o(f_m0_rvalid),
        .m1_avalid_i(m1_avalid), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
        .m1_ready_o(f_m1_ready), .m1_rdata_o(f_m1_rdata), .m1_rvalid_o(f_m1_rvalid),
        .s_avalid_o(f_s_avalid), .s_addr_o(f_s_addr), .s_wdata_o(f_s_wdata), .s_wstrb_o(f_s_wstrb),
        .s_ready_i(s_ready), .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid),
        .grant_o(f_grant), .busy_o(f_busy)
    );

    task automatic clear_inputs();
        m0_avalid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_avalid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0; s_rvalid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        clear_inputs();
        next_cycle();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        m0_avalid = 1'b1; m1_avalid = 1'b1; s_ready = 1'b1; s_rvalid = 1'b1;
        m0_addr = 32'h11; m1_addr = 32'h22; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
        @(negedge clk);
        obs = {m0_ready, m1_ready, m0_rvalid, m1_rvalid, s_avalid, busy, grant,
               f_m0_ready, f_m1_ready, f_m0_rvalid, f_m1_rvalid, f_s_avalid, f_busy, f_grant};
        checks++;
        if (obs !== 14'b0) begin
            failures++; $display("FAIL reset_outputs got=%b want=%b", obs, 14'b0);
        end
        s_ready = 1'b0;
        next_cycle();
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, s_avalid, m0_rvalid, m1_rvalid} !== 4'b0000) begin
            failures++; $display("FAIL reset_idle_cycle got=%b want=0000", {busy, s_avalid, m0_rvalid, m1_rvalid});
        end
        next_cycle();
        s_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, grant, s_avalid, m0_ready} !== 4'b1010 || s_addr !== 32'h11) begin
            failures++; $display("FAIL reset_first_tie got=%b addr=%h want=1010 addr=11", {busy, grant, s_avalid, m0_ready}, s_addr);
        end
    endtask

    task automatic test_single_read();
        logic [5:0] obs, exp;
        int r0 = 0;
        int v0 = 0;
        m0_addr = 32'h100; m0_wstrb = '0; s_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            m0_avalid = (c <= 1);
            s_rvalid  = (c == 3);
            s_rdata   = (c == 3) ? 32'hDEADBEEF : DW'($urandom);
            @(negedge clk);
            obs = {m0_ready, m1_ready, m0_rvalid, m1_rvalid, s_avalid, busy};
            exp = {c == 1, 1'b0, c == 3, 1'b0, c == 1, (c >= 1 && c <= 3)};
            r0 += int'(m0_ready);
            v0 += int'(m0_rvalid);
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL single_read c=%0d got=%b want=%b", c, obs, exp);
            end
            if (c == 1) begin
                checks++;
                if (s_addr !== 32'h100 || s_wstrb !== '0) begin
                    failures++; $display("FAIL single_read_addr got=%h/%h want=100/0", s_addr, s_wstrb);
                end
            end
            if (c == 3) begin
                checks++;
                if (m0_rdata !== 32'hDEADBEEF || m1_rdata !== 32'hDEADBEEF ||
                    f_m0_rdata !== 32'hDEADBEEF || f_m1_rdata !== 32'hDEADBEEF) begin
                    failures++; $display("FAIL single_read_data got=%h want=deadbeef", m0_rdata);
                end
            end
            next_cycle();
        end
        checks++;
        if (r0 != 1 || v0 != 1) begin
            failures++; $display("FAIL single_read_pulses ready=%0d rvalid=%0d want=1/1", r0, v0);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] rr_obs, rr_exp, fp_obs, fp_exp;
        m0_addr = 32'hA0; m0_wdata = 32'h1; m0_wstrb = 4'hF;
        m1_addr = 32'hB0; m1_wdata = 32'h2; m1_wstrb = 4'h3;
        m0_avalid = 1'b1; m1_avalid = 1'b1; s_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rr_obs = {m0_ready, m1_ready};
            rr_exp = {(c % 4) == 1, (c % 4) == 3};
            fp_obs = {f_m0_ready, f_m1_ready};
            fp_exp = {(c % 2) == 1, 1'b0};
            checks++;
            if (rr_obs !== rr_exp) begin
                failures++; $display("FAIL round_robin c=%0d got=%b want=%b", c, rr_obs, rr_exp);
            end
            checks++;
            if (fp_obs !== fp_exp) begin
                failures++; $display("FAIL fixed_prio c=%0d got=%b want=%b", c, fp_obs, fp_exp);
            end
            if ((c % 4) == 3) begin
                checks++;
                if (s_addr !== 32'hB0 || s_wdata !== 32'h2 || s_wstrb !== 4'h3 || grant !== 1'b1) begin
                    failures++; $display("FAIL round_robin_m1_payload got=%h/%h/%h g=%b", s_addr, s_wdata, s_wstrb, grant);
                end
            end
            if ((c % 2) == 1) begin
                checks++;
                if (f_s_addr !== 32'hA0 || f_s_wdata !== 32'h1 || f_s_wstrb !== 4'hF || {f_busy, f_grant} !== 2'b10) begin
                    failures++; $display("FAIL fixed_prio_payload got=%h/%h/%h bg=%b", f_s_addr, f_s_wdata, f_s_wstrb, {f_busy, f_grant});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_resp_block();
        logic [5:0] obs, exp;
        m1_addr = 32'h200; m1_wstrb = '0;
        m0_addr = 32'h300; m0_wstrb = 4'hF; m0_wdata = 32'h55;
        s_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            m1_avalid = (c <= 1);
            m0_avalid = (c >= 2 && c <= 6);
            s_rvalid  = (c == 4);
            s_rdata   = (c == 4) ? 32'h12345678 : DW'($urandom);
            @(negedge clk);
            obs = {m0_ready, m1_ready, m0_rvalid, m1_rvalid, s_avalid, busy};
            exp = {c == 6, c == 1, 1'b0, c == 4, (c == 1 || c == 6), (c >= 1 && c <= 4) || c == 6};
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL resp_block c=%0d got=%b want=%b", c, obs, exp);
            end
            if (c == 6) begin
                checks++;
                if (s_addr !== 32'h300 || grant !== 1'b0) begin
                    failures++; $display("FAIL resp_block_m0_grant got=%h g=%b want=300 g=0", s_addr, grant);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_withdraw();
        logic [4:0] obs, exp;
        m0_addr = 32'h40; m0_wstrb = 4'h1; m1_addr = 32'h80; m1_wstrb = 4'h1;
        for (int c = 0; c < 5; c++) begin
            m0_avalid = (c != 2);
            m1_avalid = (c >= 3);
            s_ready   = (c == 4);
            @(negedge clk);
            obs = {m0_ready, m1_ready, s_avalid, busy, grant};
            case (c)
                1:       exp = 5'b00110;
                2:       exp = 5'b00010;
                4:       exp = 5'b10110;
                default: exp = 5'b00000;
            endcase
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL withdraw c=%0d got=%b want=%b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_stray_reset();
        logic [3:0] obs, exp;
        m0_addr = 32'h500; m0_wstrb = '0;
        for (int c = 0; c < 6; c++) begin
            s_rvalid  = (c <= 2);
            m0_avalid = (c == 3 || c == 4);
            s_ready   = (c >= 3);
            @(negedge clk);
            obs = {m0_rvalid, m1_rvalid, m0_ready, busy};
            exp = {1'b0, 1'b0, c == 4, c >= 4};
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL stray_then_read c=%0d got=%b want=%b", c, obs, exp);
            end
            next_cycle();
        end
        clear_inputs();
        arst_n = 1'b0;
        #1;
        checks++;
        if ({busy, grant, s_avalid, m0_rvalid} !== 4'b0000) begin
            failures++; $display("FAIL async_reset_in_resp got=%b want=0000", {busy, grant, s_avalid, m0_rvalid});
        end
        next_cycle();
        arst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            s_rvalid = 1'b1;
            @(negedge clk);
            checks++;
            if ({m0_rvalid, m1_rvalid, busy} !== 3'b000) begin
                failures++; $display("FAIL late_rvalid c=%0d got=%b want=000", c, {m0_rvalid, m1_rvalid, busy});
            end
            next_cycle();
        end
        s_rvalid = 1'b0; m0_avalid = 1'b1; m1_avalid = 1'b1; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({busy, grant} !== 2'b10) begin
            failures++; $display("FAIL post_reset_tie got=%b want=10", {busy, grant});
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] ta [2][NTX];
        logic [DW-1:0] td [2][NTX];
        logic [SW-1:0] tw [2][NTX];
        int idx[2], gap[2];
        bit act[2], snap[2], rdy[2];
        int prev_acc, rd_owner, rd_wait, acc_cnt, cyc, want;
        bit rd_pend;
        logic [DW-1:0] rd_data;
        logic [1:0] rv_obs, rv_exp;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NTX; i++) begin
                ta[k][i] = AW'($urandom);
                td[k][i] = DW'($urandom);
                tw[k][i] = ($urandom_range(1) == 0) ? SW'(0) : SW'($urandom_range(15, 1));
            end
            idx[k] = 0; gap[k] = $urandom_range(2); act[k] = 1'b0; snap[k] = 1'b0;
        end
        prev_acc = 1; rd_pend = 1'b0; rd_owner = 0; rd_wait = 0; acc_cnt = 0; cyc = 0; rd_data = '0;
        while ((idx[0] < NTX || idx[1] < NTX || rd_pend) && cyc < 4000) begin
            for (int k = 0; k < 2; k++) begin
                if (!act[k] && idx[k] < NTX) begin
                    if (gap[k] == 0) act[k] = 1'b1;
                    else gap[k]--;
                end
            end
            m0_avalid = act[0];
            m1_avalid = act[1];
            if (act[0]) begin m0_addr = ta[0][idx[0]]; m0_wdata = td[0][idx[0]]; m0_wstrb = tw[0][idx[0]]; end
            if (act[1]) begin m1_addr = ta[1][idx[1]]; m1_wdata = td[1][idx[1]]; m1_wstrb = tw[1][idx[1]]; end
            s_ready = ($urandom_range(3) != 0);
            if (rd_pend && rd_wait == 0) begin
                rd_data = DW'($urandom); s_rdata = rd_data; s_rvalid = 1'b1;
            end else begin
                if (rd_pend) rd_wait--;
                s_rdata  = DW'($urandom);
                s_rvalid = !rd_pend && ($urandom_range(7) == 0);
            end
            @(negedge clk);
            if (!busy) begin snap[0] = m0_avalid; snap[1] = m1_avalid; end
            rv_exp = (rd_pend && s_rvalid) ? ((rd_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            rv_obs = {m1_rvalid, m0_rvalid};
            checks++;
            if (rv_obs !== rv_exp) begin
                failures++; $display("FAIL rand_rvalid cyc=%0d got=%b want=%b", cyc, rv_obs, rv_exp);
            end
            if (rv_exp != 2'b00) begin
                checks++;
                if (((rd_owner == 1) ? m1_rdata : m0_rdata) !== rd_data) begin
                    failures++; $display("FAIL rand_rdata cyc=%0d got=%h want=%h", cyc, (rd_owner == 1) ? m1_rdata : m0_rdata, rd_data);
                end
                rd_pend = 1'b0;
            end
            rdy[0] = m0_ready; rdy[1] = m1_ready;
            checks++;
            if (rdy[0] && rdy[1]) begin
                failures++; $display("FAIL rand_dual_ready cyc=%0d got=11 want=one-hot", cyc);
            end
            for (int k = 0; k < 2; k++) begin
                if (rdy[k] && act[k]) begin
                    want = (snap[0] && snap[1]) ? 1 - prev_acc : (snap[1] ? 1 : 0);
                    checks++;
                    if (k != want) begin
                        failures++; $display("FAIL rand_winner cyc=%0d got=m%0d want=m%0d", cyc, k, want);
                    end
                    checks++;
                    if (s_avalid !== 1'b1 || s_addr !== ta[k][idx[k]] || s_wdata !== td[k][idx[k]] || s_wstrb !== tw[k][idx[k]]) begin
                        failures++; $display("FAIL rand_payload cyc=%0d m%0d got=%h/%h/%h want=%h/%h/%h", cyc, k,
                                             s_addr, s_wdata, s_wstrb, ta[k][idx[k]], td[k][idx[k]], tw[k][idx[k]]);
                    end
                    if (tw[k][idx[k]] == '0) begin
                        rd_pend = 1'b1; rd_owner = k; rd_wait = $urandom_range(2);
                    end
                    prev_acc = k; act[k] = 1'b0; idx[k]++; gap[k] = $urandom_range(2); acc_cnt++;
                end else if (rdy[k]) begin
                    checks++;
                    failures++; $display("FAIL rand_spurious_ready cyc=%0d m%0d got=1 want=0", cyc, k);
                end
            end
            next_cycle();
            cyc++;
        end
        checks++;
        if (cyc >= 4000 || acc_cnt != 2 * NTX) begin
            failures++; $display("FAIL rand_completion accepted=%0d want=%0d cycles=%0d", acc_cnt, 2 * NTX, cyc);
        end
    endtask

    initial begin
        arst_n = 1'b0;
        clear_inputs();
        #2;
        test_reset();
        do_reset();
        test_single_read();
        do_reset();
        test_arbitration();
        do_reset();
        test_resp_block();
        do_reset();
        test_withdraw();
        do_reset();
        test_stray_reset();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
